// File: rtl/cnt_defs.sv
// Shared definitions for the counter run controller: data width and FSM state codes.
package cnt_defs;

  localparam int unsigned CNT_W = 12;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/cnt_step_tracker.sv
// Step counter: cleared when a run is accepted, +1 on every enabled counter cycle, wraps at W bits.
module cnt_step_tracker
  import cnt_defs::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] steps
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      steps <= '0;
    end else if (clr) begin
      steps <= '0;
    end else if (inc) begin
      steps <= steps + W'(1);
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Run controller for the loadable up-counter: load preset, count to limit, stop, pulse done.
// Supports pause (hold) and abort (end without done); reports enabled steps.
module cnt_seq_ctrl
  import cnt_defs::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic [W-1:0] preset,
  input  logic [W-1:0] limit,
  input  logic [W-1:0] count_in,
  output logic         cnt_enable,
  output logic         cnt_load,
  output logic [W-1:0] cnt_loadbits,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] steps
);

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic [W-1:0] limit_q;
  logic         accept;
  logic         at_limit;

  assign at_limit = (count_in == limit_q);

  // Next-state logic; enable is combinational so the counter stops exactly at the limit.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          accept  = 1'b1;
        end
      end
      LOAD: begin
        state_d = abort ? IDLE : RUN;
      end
      RUN: begin
        cnt_enable = !pause && !abort && !at_limit;
        if (abort) begin
          state_d = IDLE;
        end else if (at_limit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_load     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cnt_loadbits <= '0;
      limit_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_load <= (state_d == LOAD);
      busy     <= (state_d == LOAD) || (state_d == RUN);
      done     <= (state_d == DONE);
      if (accept) begin
        cnt_loadbits <= preset;
        limit_q      <= limit;
      end
    end
  end

  cnt_step_tracker #(.W(W)) u_steps (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .inc   (cnt_enable),
    .steps (steps)
  );

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl driving a behavioural 12-bit loadable counter, checked per cycle
// against a run-level model of the expected count sequence, done timing and step total.
module tb_cnt_seq_ctrl;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] preset = '0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] count = '0;
  logic         cnt_enable;
  logic         cnt_load;
  logic [W-1:0] cnt_loadbits;
  logic         busy;
  logic         done;
  logic [W-1:0] steps;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pause        (pause),
    .abort        (abort),
    .preset       (preset),
    .limit        (limit),
    .count_in     (count),
    .cnt_enable   (cnt_enable),
    .cnt_load     (cnt_load),
    .cnt_loadbits (cnt_loadbits),
    .busy         (busy),
    .done         (done),
    .steps        (steps)
  );

  // Counter (contador): load beats enable, +1 per enabled edge, wraps naturally.
  always_ff @(posedge clk) begin
    if (cnt_load) count <= cnt_loadbits;
    else if (cnt_enable) count <= count + W'(1);
  end

  task automatic test_reset();
    start = 1'b1;
    preset = 12'h123;
    limit = 12'h456;
    repeat (2) @(negedge clk);
    checks++;
    if ({cnt_enable, cnt_load, busy, done} !== 4'b0000 || cnt_loadbits !== '0 || steps !== '0) begin
      fails++;
      $display("FAIL reset_state: en=%b load=%b busy=%b done=%b loadbits=%h steps=%h, required all 0",
               cnt_enable, cnt_load, busy, done, cnt_loadbits, steps);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  // Full run with an optional pause window [ps, ps+pl) in cycles counted from the start edge.
  task automatic run_case(input string name, input logic [W-1:0] p, input logic [W-1:0] l,
                          input int ps, input int pl);
    logic [W-1:0] exp_cnt[$];
    logic [W-1:0] m;
    logic [W-1:0] d;
    int k;
    int done_k;
    logic paused;
    logic exp_en;
    d = l - p;
    m = p;
    exp_cnt.push_back('0);
    exp_cnt.push_back(p);
    k = 1;
    while (m != l) begin
      if (!(k >= ps && k < ps + pl)) m = m + W'(1);
      k++;
      exp_cnt.push_back(m);
    end
    done_k = k + 1;
    for (int i = 0; i < 3; i++) exp_cnt.push_back(l);

    @(negedge clk);
    preset = p;
    limit  = l;
    start  = 1'b1;
    for (int c = 0; c <= done_k + 2; c++) begin
      @(negedge clk);
      checks++;
      if (cnt_load !== (c == 0)) begin
        fails++;
        $display("FAIL %s_load c=%0d: cnt_load=%b, required %b", name, c, cnt_load, (c == 0));
      end
      checks++;
      if (busy !== (c < done_k)) begin
        fails++;
        $display("FAIL %s_busy c=%0d: busy=%b, required %b", name, c, busy, (c < done_k));
      end
      checks++;
      if (done !== (c == done_k)) begin
        fails++;
        $display("FAIL %s_done c=%0d: done=%b, required %b", name, c, done, (c == done_k));
      end
      if (c >= 1) begin
        checks++;
        if (count !== exp_cnt[c]) begin
          fails++;
          $display("FAIL %s_count c=%0d: count=%h, required %h", name, c, count, exp_cnt[c]);
        end
      end
      if (c == 0) begin
        start  = 1'b0;
        preset = W'($urandom);
        limit  = W'($urandom);
      end
      start  = (c == 2);
      paused = (c >= ps && c < ps + pl);
      pause  = paused;
      #1;
      exp_en = (c >= 1) && (c < done_k) && !paused && (exp_cnt[c] != l);
      checks++;
      if (cnt_enable !== exp_en) begin
        fails++;
        $display("FAIL %s_enable c=%0d: cnt_enable=%b, required %b", name, c, cnt_enable, exp_en);
      end
    end
    pause = 1'b0;
    start = 1'b0;
    checks++;
    if (steps !== d || cnt_loadbits !== p) begin
      fails++;
      $display("FAIL %s_steps: steps=%h loadbits=%h, required %h %h", name, steps, cnt_loadbits, d, p);
    end
  endtask

  task automatic test_basic();
    run_case("basic", 12'h901, 12'h905, -1, 0);
  endtask

  task automatic test_wrap();
    run_case("wrap", 12'hFFE, 12'h001, -1, 0);
  endtask

  task automatic test_equal();
    run_case("equal", 12'h800, 12'h800, -1, 0);
  endtask

  task automatic test_pause();
    run_case("pause", 12'h901, 12'h90A, 3, 3);
    run_case("pause_in_load", 12'h210, 12'h213, 0, 1);
  endtask

  task automatic test_abort();
    int c;
    @(negedge clk);
    preset = 12'h901;
    limit  = 12'h90A;
    start  = 1'b1;
    c = 0;
    @(negedge clk);
    start = 1'b0;
    while (!(busy && count == 12'h903) && c < 20) begin
      @(negedge clk);
      c++;
      start = (c == 2);
      preset = 12'h555;
    end
    start = 1'b0;
    checks++;
    if (c >= 20) begin
      fails++;
      $display("FAIL abort_reach_903: count=%h busy=%b, required 903 1", count, busy);
    end
    abort = 1'b1;
    #1;
    checks++;
    if (cnt_enable !== 1'b0) begin
      fails++;
      $display("FAIL abort_enable: cnt_enable=%b, required 0", cnt_enable);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 12'h903 || steps !== 12'd2 || cnt_loadbits !== 12'h901) begin
      fails++;
      $display("FAIL abort_idle: busy=%b done=%b count=%h steps=%h loadbits=%h, required 0 0 903 002 901",
               busy, done, count, steps, cnt_loadbits);
    end
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || count !== 12'h903) begin
        fails++;
        $display("FAIL abort_quiet i=%0d: done=%b busy=%b count=%h, required 0 0 903", i, done, busy, count);
      end
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    preset = 12'h901;
    limit  = 12'h90A;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({cnt_enable, cnt_load, busy, done} !== 4'b0000 || cnt_loadbits !== '0 || steps !== '0) begin
      fails++;
      $display("FAIL reset_midrun: en=%b load=%b busy=%b done=%b loadbits=%h steps=%h, required all 0",
               cnt_enable, cnt_load, busy, done, cnt_loadbits, steps);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt_enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: busy=%b en=%b, required 0 0", busy, cnt_enable);
    end
    reset = 1'b1;
    run_case("after_reset", 12'h0F0, 12'h0F6, -1, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] p;
    int d;
    for (int r = 0; r < 8; r++) begin
      p = W'($urandom);
      d = int'($urandom_range(0, 30));
      run_case("random", p, p + W'(d), int'($urandom_range(0, d)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    run_case("b2b_a", 12'h010, 12'h012, -1, 0);
    run_case("b2b_b", 12'hFFF, 12'h000, 1, 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_equal();
    test_pause();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
